// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer. Selects the VGA screen, pulses the round reset and
// gates player movement from keycodes, frame ticks and the two players' scores.
module game_flow_ctrl #(
  parameter int unsigned WIN_POINTS       = 10,
  parameter int unsigned COUNTDOWN_FRAMES = 120,
  parameter int unsigned WIN_HOLD_FRAMES  = 600,
  parameter logic [15:0] KEY_START        = 16'h0029,
  parameter logic [15:0] KEY_RESTART      = 16'h005A,
  parameter logic [15:0] KEY_ABORT        = 16'h0076
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic [15:0] keycode,
  input  logic [4:0]  points_1,
  input  logic [4:0]  points_2,
  output logic [1:0]  screen,
  output logic        game_rst,
  output logic        game_en,
  output logic [7:0]  round_cnt
);

  localparam int unsigned CD_W   = (COUNTDOWN_FRAMES > 0) ? $clog2(COUNTDOWN_FRAMES + 1) : 1;
  localparam int unsigned HOLD_W = $clog2(WIN_HOLD_FRAMES + 1);

  localparam logic [CD_W-1:0]   CD_INIT   = CD_W'(COUNTDOWN_FRAMES);
  localparam logic [CD_W-1:0]   CD_ONE    = CD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(WIN_HOLD_FRAMES);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [4:0]        WIN_P     = 5'(WIN_POINTS);

  typedef enum logic [1:0] {
    ST_START    = 2'd0,
    ST_GAME     = 2'd1,
    ST_PLAYER_1 = 2'd2,
    ST_PLAYER_2 = 2'd3
  } state_t;

  state_t              r_state;
  logic [15:0]         r_keycode_q;
  logic [CD_W-1:0]     r_cd;
  logic [1:0]          r_guard;
  logic [HOLD_W-1:0]   r_hold;

  logic w_press_start;
  logic w_press_restart;
  logic w_press_abort;
  logic w_enter_game;
  logic w_win;
  logic w_p1_leads;

  // A held code fires once: only the first cycle a code differs from last cycle counts.
  assign w_press_start   = (keycode == KEY_START)   && (r_keycode_q != KEY_START);
  assign w_press_restart = (keycode == KEY_RESTART) && (r_keycode_q != KEY_RESTART);
  assign w_press_abort   = (keycode == KEY_ABORT)   && (r_keycode_q != KEY_ABORT);

  assign w_enter_game = ((r_state == ST_START) && w_press_start) ||
                        (((r_state == ST_PLAYER_1) || (r_state == ST_PLAYER_2)) && w_press_restart);
  assign w_win        = (points_1 >= WIN_P) || (points_2 >= WIN_P);
  assign w_p1_leads   = (points_1 >= points_2);

  assign screen = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_START;
      r_keycode_q <= '0;
      r_cd        <= '0;
      r_guard     <= '0;
      r_hold      <= '0;
      game_rst    <= 1'b0;
      game_en     <= 1'b0;
      round_cnt   <= '0;
    end else begin
      r_keycode_q <= keycode;
      game_rst    <= 1'b0;
      if (w_enter_game) begin
        r_state  <= ST_GAME;
        game_rst <= 1'b1;
        r_cd     <= CD_INIT;
        r_guard  <= 2'd2;
        game_en  <= (COUNTDOWN_FRAMES == 0);
      end else begin
        unique case (r_state)
          ST_START: begin
            game_en <= 1'b0;
          end
          ST_GAME: begin
            if (r_guard != '0) r_guard <= r_guard - 2'd1;
            if (w_press_abort) begin
              r_state <= ST_START;
              game_en <= 1'b0;
            end else if ((r_guard == '0) && w_win) begin
              r_state   <= w_p1_leads ? ST_PLAYER_1 : ST_PLAYER_2;
              round_cnt <= round_cnt + 8'd1;
              r_hold    <= HOLD_INIT;
              game_en   <= 1'b0;
            end else if (frame_tick && (r_cd != '0)) begin
              r_cd    <= r_cd - CD_ONE;
              game_en <= (r_cd == CD_ONE);
            end else begin
              game_en <= (r_cd == '0);
            end
          end
          ST_PLAYER_1, ST_PLAYER_2: begin
            game_en <= 1'b0;
            // Restart is handled above, so it already wins over a same-cycle expiry.
            if (frame_tick && (r_hold != '0)) begin
              r_hold <= r_hold - HOLD_ONE;
              if (r_hold == HOLD_ONE) r_state <= ST_START;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Top-level sequencer for the two-player game. Drives the 2-bit `screen` code that selects which VGA screen pipeline is shown: START=0, GAME=1, PLAYER_1=2, PLAYER_2=3.
- Decides transitions from keyboard make-codes, the per-frame tick and the two players' scores.
- Issues a one-cycle round reset to the game datapath and a movement enable.
- Sits between the PS/2 keycode source and the screen selector / draw_game logic.

Parameters:
- WIN_POINTS, 10: score (1..31) at which a player wins.
- COUNTDOWN_FRAMES, 120: frames after round start with movement disabled (0 allowed).
- WIN_HOLD_FRAMES, 600: frames a winner screen is held before auto-return to START (≥1).
- KEY_START, 16'h0029: keycode that starts a round from START (space).
- KEY_RESTART, 16'h005A: keycode that restarts a round from a winner screen (enter).
- KEY_ABORT, 16'h0076: keycode that abandons a running round (esc).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per frame (start of vblank)
- keycode  in  16  latest PS/2 code; held until the next code; F0xx = break
- points_1  in  5  player 1 score from draw_game
- points_2  in  5  player 2 score from draw_game
- screen  out  2  screen select: 0 START, 1 GAME, 2 PLAYER_1, 3 PLAYER_2
- game_rst  out  1  one-cycle pulse that clears scores and positions
- game_en  out  1  movement enable for both players
- round_cnt  out  8  completed rounds; wraps 255→0

Behaviour:
- All outputs are registered.
- Reset values: screen=0 (START), game_rst=0, game_en=0, round_cnt=0, keycode_q=0, all counters 0.
- Key press detect: press(K) = (keycode==K) && (keycode_q!=K). keycode_q updates every cycle. A held code fires once; the same key fires again only after keycode changes (e.g. a break code arrives).
- START:
  - game_en=0.
  - press(KEY_START) → GAME next cycle; game_rst=1 for exactly that first GAME cycle; countdown loaded with COUNTDOWN_FRAMES; guard counter loaded with 2.
  - All other keys are ignored.
- GAME:
  - Countdown decrements on each frame_tick while nonzero.
  - game_en=1 iff countdown==0 and the state is GAME.
  - Guard counter decrements every clock to 0. Score checks are inhibited while guard≠0, so stale pre-reset scores are never sampled.
  - With guard==0: if points_1≥WIN_POINTS or points_2≥WIN_POINTS:
    - winner = PLAYER_1 if points_1≥points_2, else PLAYER_2 (ties go to player 1);
    - go to the winner state; round_cnt increments; game_en drops in the same cycle the screen changes.
  - press(KEY_ABORT) → START, round_cnt unchanged. Abort has priority over a win detected in the same cycle.
- PLAYER_1 / PLAYER_2:
  - On entry the hold counter loads WIN_HOLD_FRAMES and decrements on frame_tick.
  - press(KEY_RESTART) → GAME with the same entry actions as from START (game_rst pulse, countdown and guard loaded).
  - Hold counter reaching 0 → START.
  - If restart and expiry occur in the same cycle, restart wins.
  - KEY_START and KEY_ABORT are ignored.
- game_rst is never asserted for more than one consecutive cycle. It is asserted only on entry to GAME.
- frame_tick in the same cycle as a state entry: the counter loads; the tick is not counted.
- Reset mid-round returns to START within one cycle. game_rst is not pulsed by rst; downstream blocks use rst directly.
- Counter widths are $clog2(param+1). No arithmetic overflow is possible except round_cnt, which wraps.

Test Plan:
- After rst, keycode=16'h0029 for 1 cycle → next cycle screen=1 and game_rst=1 for exactly 1 cycle; game_en=0 for 120 frame_ticks, then 1. Holding 0029 for 50 cycles gives no second game_rst.
- In GAME after countdown, drive points_1=10, points_2=3 → next cycle screen=2, game_en=0, round_cnt=1. points_1=9, points_2=10 → screen=3. points_1=10, points_2=10 in the same cycle → screen=2.
- Present points_1=12 during the first two cycles after game_rst (guard) → no transition. Score drops to 0 afterwards → stays in GAME.
- In PLAYER_2, issue 600 frame_ticks with no key → screen=0 exactly on the 600th tick; round_cnt is kept.
- In PLAYER_1, keycode=16'h005A on the same cycle the hold counter expires → screen=1, game_rst pulses. The sequence 005A, F05A, 005A in GAME causes no transition.
- In GAME, keycode=16'h0076 in the same cycle points_2 reaches 10 → screen=0, round_cnt unchanged. Assert rst mid-countdown → screen=0, game_en=0, round_cnt=0 next cycle.
